// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the memory
// stage (port M) and the program loader / debug port (port L).
//   CLK, RST_N          : clock, asynchronous active-low reset
//   m_*/l_* req side    : req/we/addr/wdata, req held until ack
//   m_*/l_* resp side   : one-cycle ack with rdata and err
//   mem_*               : read/write strobes, address, write data, read data, error
//   busy                : high whenever the FSM is not IDLE
// Round-robin grant, range/alignment check before any strobe, all outputs registered.
module dmem_arbiter #(
  parameter int unsigned DATA_WID   = 64,
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned ALIGN_BITS = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                m_req,
  input  logic                m_we,
  input  logic [DATA_WID-1:0] m_addr,
  input  logic [DATA_WID-1:0] m_wdata,
  output logic                m_ack,
  output logic [DATA_WID-1:0] m_rdata,
  output logic                m_err,
  input  logic                l_req,
  input  logic                l_we,
  input  logic [DATA_WID-1:0] l_addr,
  input  logic [DATA_WID-1:0] l_wdata,
  output logic                l_ack,
  output logic [DATA_WID-1:0] l_rdata,
  output logic                l_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  input  logic [DATA_WID-1:0] mem_rdata,
  input  logic                mem_error,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

  // First address whose 8-byte word would run past the end of memory.
  localparam logic [DATA_WID-1:0] ADDR_LIMIT = DATA_WID'(MEM_BYTES - 7);

  state_e              state_q, state_d;
  logic                last_l_q, last_l_d;   // 1: last grant went to L
  logic                win_l_q, win_l_d;     // owner of the current access
  logic                we_q, we_d;
  logic                m_ack_q, m_ack_d, m_err_q, m_err_d;
  logic                l_ack_q, l_ack_d, l_err_q, l_err_d;
  logic [DATA_WID-1:0] m_rdata_q, m_rdata_d, l_rdata_q, l_rdata_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [DATA_WID-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;

  logic                sel_l;
  logic                sel_we;
  logic [DATA_WID-1:0] sel_addr, sel_wdata, rd_val;
  logic                addr_bad;

  // Next-state, grant and registered-output computation.
  always_comb begin
    state_d     = state_q;
    last_l_d    = last_l_q;
    win_l_d     = win_l_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    m_ack_d     = 1'b0;
    m_err_d     = 1'b0;
    m_rdata_d   = '0;
    l_ack_d     = 1'b0;
    l_err_d     = 1'b0;
    l_rdata_d   = '0;

    // On a tie, L wins only if M was granted last.
    sel_l     = l_req && (!m_req || !last_l_q);
    sel_we    = sel_l ? l_we    : m_we;
    sel_addr  = sel_l ? l_addr  : m_addr;
    sel_wdata = sel_l ? l_wdata : m_wdata;
    addr_bad  = (sel_addr >= ADDR_LIMIT) || (sel_addr[ALIGN_BITS-1:0] != '0);
    rd_val    = we_q ? '0 : mem_rdata;

    case (state_q)
      IDLE: begin
        if (m_req || l_req) begin
          win_l_d     = sel_l;
          last_l_d    = sel_l;
          we_d        = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          if (addr_bad) begin
            // Rejected access answers directly, never touching memory.
            state_d = ERR;
            m_ack_d = !sel_l;
            m_err_d = !sel_l;
            l_ack_d = sel_l;
            l_err_d = sel_l;
          end else begin
            state_d     = ACCESS;
            mem_write_d = sel_we;
            mem_read_d  = !sel_we;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (win_l_q) begin
          l_ack_d   = 1'b1;
          l_rdata_d = rd_val;
          l_err_d   = mem_error;
        end else begin
          m_ack_d   = 1'b1;
          m_rdata_d = rd_val;
          m_err_d   = mem_error;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      last_l_q    <= 1'b1;
      win_l_q     <= 1'b0;
      we_q        <= 1'b0;
      m_ack_q     <= 1'b0;
      m_err_q     <= 1'b0;
      m_rdata_q   <= '0;
      l_ack_q     <= 1'b0;
      l_err_q     <= 1'b0;
      l_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_l_q    <= last_l_d;
      win_l_q     <= win_l_d;
      we_q        <= we_d;
      m_ack_q     <= m_ack_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
      l_ack_q     <= l_ack_d;
      l_err_q     <= l_err_d;
      l_rdata_q   <= l_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign m_ack     = m_ack_q;
  assign m_err     = m_err_q;
  assign m_rdata   = m_rdata_q;
  assign l_ack     = l_ack_q;
  assign l_err     = l_err_q;
  assign l_rdata   = l_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, contention and
// reset-abort sequences, then random single-port accesses checked
// against a word-addressed reference memory.
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 1024;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic        m_ack, m_err;
  logic [63:0] m_rdata;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [63:0] l_addr = '0, l_wdata = '0;
  logic        l_ack, l_err;
  logic [63:0] l_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_error = 1'b0;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Environment memory (128 words) and expected-contents reference.
  logic [63:0] tb_mem [128] = '{default: '0};
  logic [63:0] ref_mem [logic [63:0]];

  dmem_arbiter #(.DATA_WID(64), .MEM_BYTES(MEM_BYTES), .ALIGN_BITS(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata), .l_err(l_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = tb_mem[mem_addr[9:3]];
  always @(posedge CLK) if (mem_write) tb_mem[mem_addr[9:3]] <= mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {63'd0, act}, {63'd0, exp});
  endtask

  function automatic bit model_bad(input logic [63:0] a);
    return (a > 64'(MEM_BYTES) - 64'd8) || (a % 64'd8 != 64'd0);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  // Cycle-level invariants.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      chkb("ack_overlap", m_ack & l_ack, 1'b0);
      chkb("strobe_both", mem_read & mem_write, 1'b0);
      chkb("ack_without_busy", (m_ack | l_ack) & ~busy, 1'b0);
    end
  end

  // One access from an idle start; inputs are scrambled and req dropped
  // right after the grant edge, which must not disturb the access.
  task automatic run_vec(input string nm, input bit pl, input bit we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input bit merr, input bit exp_bad,
                         input logic [63:0] exp_rd, input bit exp_err);
    if (pl) begin l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; end
    else    begin m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; end
    mem_error = merr;
    @(negedge CLK);
    m_req = 1'b0; l_req = 1'b0;
    m_we = 1'($urandom); l_we = 1'($urandom);
    m_addr = {32'($urandom), 32'($urandom)}; l_addr = {32'($urandom), 32'($urandom)};
    m_wdata = {32'($urandom), 32'($urandom)}; l_wdata = {32'($urandom), 32'($urandom)};
    if (!exp_bad) begin
      chkb({nm, ".mem_read"}, mem_read, !we);
      chkb({nm, ".mem_write"}, mem_write, we);
      chk({nm, ".mem_addr"}, mem_addr, addr);
      if (we) chk({nm, ".mem_wdata"}, mem_wdata, wdata);
      chkb({nm, ".early_ack"}, m_ack | l_ack, 1'b0);
      @(negedge CLK);
    end else begin
      chkb({nm, ".strobe"}, mem_read | mem_write, 1'b0);
    end
    chkb({nm, ".strobe_in_resp"}, mem_read | mem_write, 1'b0);
    chkb({nm, ".ack"}, pl ? l_ack : m_ack, 1'b1);
    chkb({nm, ".loser_ack"}, pl ? m_ack : l_ack, 1'b0);
    chk({nm, ".rdata"}, pl ? l_rdata : m_rdata, exp_rd);
    chkb({nm, ".err"}, pl ? l_err : m_err, exp_err);
    chkb({nm, ".loser_err"}, pl ? m_err : l_err, 1'b0);
    if (we && !model_bad(addr)) ref_mem[addr] = wdata;
    mem_error = 1'b0;
    @(negedge CLK);
    chkb({nm, ".idle_busy"}, busy, 1'b0);
    chkb({nm, ".idle_ack"}, m_ack | l_ack, 1'b0);
  endtask

  typedef struct {
    string       name;
    bit          pl;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          merr;
    bit          exp_bad;
    logic [63:0] exp_rd;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(input string n, input bit pl, input bit we,
                              input logic [63:0] a, input logic [63:0] wd, input bit me,
                              input bit eb, input logic [63:0] er, input bit ee);
    vec_t v;
    v.name = n; v.pl = pl; v.we = we; v.addr = a; v.wdata = wd; v.merr = me;
    v.exp_bad = eb; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    bit          pl, we, merr, bad, exp_m, exp_l;
    logic [63:0] addr, wdata;

    tbl.push_back(mk("m_wr_08",      0, 1, 64'h008, 64'h11,        0, 0, 64'h0,        0));
    tbl.push_back(mk("m_rd_08",      0, 0, 64'h008, 64'h0,         0, 0, 64'h11,       0));
    tbl.push_back(mk("m_rd_03",      0, 0, 64'h003, 64'h0,         0, 1, 64'h0,        1));
    tbl.push_back(mk("m_rd_400",     0, 0, 64'h400, 64'h0,         0, 1, 64'h0,        1));
    tbl.push_back(mk("l_rd_08_merr", 1, 0, 64'h008, 64'h0,         1, 0, 64'h11,       1));
    tbl.push_back(mk("l_wr_3f8",     1, 1, 64'h3F8, 64'hDEADBEEF,  0, 0, 64'h0,        0));
    tbl.push_back(mk("m_rd_3f8",     0, 0, 64'h3F8, 64'h0,         0, 0, 64'hDEADBEEF, 0));
    tbl.push_back(mk("l_wr_3f9",     1, 1, 64'h3F9, 64'h12345678,  0, 1, 64'h0,        1));
    tbl.push_back(mk("l_rd_3ff",     1, 0, 64'h3FF, 64'h0,         0, 1, 64'h0,        1));
    tbl.push_back(mk("m_wr_400",     0, 1, 64'h400, 64'h99,        1, 1, 64'h0,        1));
    tbl.push_back(mk("l_rd_3f8",     1, 0, 64'h3F8, 64'h0,         0, 0, 64'hDEADBEEF, 0));
    tbl.push_back(mk("m_wr_10_merr", 0, 1, 64'h010, 64'h77,        1, 0, 64'h0,        1));

    // Reset values.
    @(negedge CLK);
    chkb("rst.m_ack", m_ack, 1'b0);
    chkb("rst.l_ack", l_ack, 1'b0);
    chkb("rst.busy", busy, 1'b0);
    chkb("rst.strobes", mem_read | mem_write, 1'b0);
    chkb("rst.errs", m_err | l_err, 1'b0);
    chk("rst.mem_addr", mem_addr, 64'h0);
    chk("rst.mem_wdata", mem_wdata, 64'h0);
    chk("rst.m_rdata", m_rdata, 64'h0);
    chk("rst.l_rdata", l_rdata, 64'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    foreach (tbl[i])
      run_vec(tbl[i].name, tbl[i].pl, tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].merr, tbl[i].exp_bad, tbl[i].exp_rd, tbl[i].exp_err);

    // Continuous contention after reset: M, L, M, L at 3-cycle spacing.
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h008;
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'h3F8;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      exp_m = (c % 3 == 2) && ((c / 3) % 2 == 0);
      exp_l = (c % 3 == 2) && ((c / 3) % 2 == 1);
      chkb($sformatf("rr.c%0d.m_ack", c), m_ack, exp_m);
      chkb($sformatf("rr.c%0d.l_ack", c), l_ack, exp_l);
      if (exp_m) chk($sformatf("rr.c%0d.m_rdata", c), m_rdata, ref_rd(64'h008));
      if (exp_l) chk($sformatf("rr.c%0d.l_rdata", c), l_rdata, ref_rd(64'h3F8));
      if (c == 11) begin m_req = 1'b0; l_req = 1'b0; end
    end
    @(negedge CLK);

    // Reset in the middle of an M write: strobe drops, nothing completes.
    m_req = 1'b1; m_we = 1'b1; m_addr = 64'h020; m_wdata = 64'h55;
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'h008;
    @(negedge CLK);
    chkb("rstmid.write_before", mem_write, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chkb("rstmid.write_after", mem_write, 1'b0);
    chkb("rstmid.read_after", mem_read, 1'b0);
    chkb("rstmid.busy_after", busy, 1'b0);
    m_req = 1'b0; l_req = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chkb($sformatf("rstmid.c%0d.no_ack", c), m_ack | l_ack, 1'b0);
    end
    chk("rstmid.no_mem_write", tb_mem[4], 64'h0);
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h008;
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'h3F8;
    @(negedge CLK);
    chk("rstmid.first_grant_addr", mem_addr, 64'h008);
    @(negedge CLK);
    chkb("rstmid.m_ack", m_ack, 1'b1);
    chkb("rstmid.l_ack", l_ack, 1'b0);
    m_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chkb("rstmid.l_ack_later", l_ack, 1'b1);
    chk("rstmid.l_rdata", l_rdata, ref_rd(64'h3F8));
    l_req = 1'b0;
    @(negedge CLK);

    // Random single-port accesses against the reference memory.
    for (int n = 0; n < 80; n++) begin
      pl = 1'($urandom);
      we = 1'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    addr = {54'd0, 7'($urandom_range(0, 127)), 3'd0};
        2:       addr = {54'd0, 7'($urandom), 3'($urandom_range(1, 7))};
        default: addr = {32'($urandom), 32'($urandom)} | 64'h400;
      endcase
      wdata = {32'($urandom), 32'($urandom)};
      merr  = ($urandom_range(0, 3) == 0);
      bad   = model_bad(addr);
      run_vec($sformatf("rnd%0d", n), pl, we, addr, wdata, merr, bad,
              (bad || we) ? 64'd0 : ref_rd(addr), bad || merr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
